// File: rtl/akarin_fetch_queue.sv
// Instruction fetch unit: keeps at most one bus read in flight and buffers the
// returned {pc, inst} pairs in a DEPTH-entry circular FIFO feeding decode.
module akarin_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     mem_req,
  output logic [XLEN-1:0]          mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [XLEN-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt, pending_pc, redirect_target;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            deq, enq, grant;
  logic [CW-1:0]   count_after_deq, count_nxt;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign inst_valid      = (count != '0);
  assign inst_data       = inst_mem[rd_ptr];
  assign inst_pc         = pc_mem[rd_ptr];
  assign mem_addr        = fetch_pc;

  assign deq             = inst_valid & inst_ready & ~stall & ~redirect_valid;
  assign count_after_deq = count - CW'(deq);
  assign count_nxt       = redirect_valid ? '0 : count_after_deq + CW'(enq);

  // A redirect always retargets fetch_pc; a response already in flight must
  // still be absorbed (DRAIN) before the new address can go out.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = redirect_valid ? redirect_target : fetch_pc;
    mem_req      = 1'b0;
    enq          = 1'b0;
    grant        = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid || (count_after_deq < CW'(DEPTH)))
          state_nxt = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (redirect_valid) begin
          state_nxt = mem_gnt ? DRAIN : REQ;
        end else if (mem_gnt) begin
          grant        = 1'b1;
          fetch_pc_nxt = fetch_pc + XLEN'(4);
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_nxt = mem_rvalid ? REQ : DRAIN;
        end else if (mem_rvalid) begin
          enq       = 1'b1;
          state_nxt = (count_after_deq < CW'(DEPTH - 1)) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid)
          state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      if (grant)
        pending_pc <= fetch_pc;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        if (enq) wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Storage is data only; its contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= pending_pc;
      inst_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_akarin_fetch_queue.sv
// Bench for akarin_fetch_queue: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level queue model.
module tb_akarin_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, redirect_valid = 1'b0, mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0, mem_rdata = '0;
  logic        mem_req, inst_valid;
  logic [31:0] mem_addr, inst_data, inst_pc;
  logic [2:0]  count;

  akarin_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Model: buffered words, next fetch address, and the single in-flight read.
  ent_t        q[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_pend_pc  = '0;
  bit          m_out = 1'b0, m_discard = 1'b0;
  int          checks = 0, errors = 0, grants = 0, idle_run = 0;
  logic        rst_val = 1'b0;
  bit          rand_data = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out      = 1'b0;
    m_discard  = 1'b0;
    m_fetch_pc = RESET_PC;
    m_pend_pc  = '0;
    idle_run   = 0;
  endtask

  task automatic check_outputs();
    chk("count", 64'(count), 64'(q.size()));
    chk("inst_valid", 64'(inst_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("inst_pc", 64'(inst_pc), 64'(q[0].pc));
      chk("inst_data", 64'(inst_data), 64'(q[0].data));
    end
    if (mem_req) begin
      chk("mem_addr", 64'(mem_addr), 64'(m_fetch_pc));
      chk("single_outstanding", 64'(m_out), 64'(0));
    end
    if (rst && !m_out && !mem_req && q.size() < DEPTH) idle_run++;
    else idle_run = 0;
    chk("fetch_liveness", 64'(idle_run > 2), 64'(0));
  endtask

  task automatic model_step();
    bit   deq, g, rv;
    ent_t e;
    deq = (q.size() != 0) && inst_ready && !stall;
    g   = mem_req && mem_gnt;
    rv  = mem_rvalid && m_out;
    if (g) grants++;
    if (redirect_valid) begin
      q.delete();
      if (rv) m_out = 1'b0;
      if (m_out) m_discard = 1'b1;
      if (g) begin
        m_out     = 1'b1;
        m_discard = 1'b1;
      end
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (deq) void'(q.pop_front());
      if (rv) begin
        if (!m_discard) begin
          e.pc   = m_pend_pc;
          e.data = mem_rdata;
          q.push_back(e);
        end
        m_out = 1'b0;
      end
      if (g) begin
        m_out      = 1'b1;
        m_discard  = 1'b0;
        m_pend_pc  = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  // One clock: drive after the edge, compare and advance the model mid-cycle.
  task automatic cycle(input int gnt_pct, input int rv_pct, input logic rdy, input logic st,
                       input logic rd, input logic [31:0] rpc, input bit force_rv);
    @(posedge clk);
    #1;
    rst            = rst_val;
    inst_ready     = rdy;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    mem_gnt        = mem_req && (int'($urandom_range(99)) < gnt_pct);
    mem_rvalid     = force_rv || (m_out && (int'($urandom_range(99)) < rv_pct));
    mem_rdata      = rand_data ? $urandom : (32'hC0DE_0000 ^ m_pend_pc);
    @(negedge clk);
    if (!rst) model_reset();
    check_outputs();
    if (rst) model_step();
  endtask

  initial begin
    int g0, gp, rp;
    rst_val = 1'b0;
    repeat (3) cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("reset_mem_req", 64'(mem_req), 64'(0));
    chk("reset_inst_valid", 64'(inst_valid), 64'(0));
    chk("reset_count", 64'(count), 64'(0));

    // Streaming fetch with immediate grant/response.
    rst_val = 1'b1;
    cycle(100, 100, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stream_idle_after_reset", 64'(mem_req), 64'(0));
    cycle(100, 100, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stream_first_req", 64'(mem_req), 64'(1));
    chk("stream_addr0", 64'(mem_addr), 64'h0);
    repeat (2) cycle(100, 100, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stream_addr4", 64'(mem_addr), 64'h4);
    chk("stream_pc0", 64'(inst_pc), 64'h0);
    chk("stream_data0", 64'(inst_data), 64'hC0DE_0000);
    repeat (2) cycle(100, 100, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stream_addr8", 64'(mem_addr), 64'h8);
    chk("stream_pc4", 64'(inst_pc), 64'h4);

    // Fill with decode blocked, then free one slot.
    rst_val = 1'b0;
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst_val = 1'b1;
    g0 = grants;
    repeat (14) cycle(100, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("fill_grants", 64'(grants - g0), 64'(4));
    chk("fill_count", 64'(count), 64'(4));
    chk("fill_no_req", 64'(mem_req), 64'(0));
    cycle(100, 100, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(100, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("refill_req", 64'(mem_req), 64'(1));
    chk("refill_addr", 64'(mem_addr), 64'h10);
    chk("refill_count", 64'(count), 64'(3));

    // Redirect while waiting; late response must be dropped.
    cycle(100, 0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("drain_count", 64'(count), 64'(0));
    chk("drain_inst_valid", 64'(inst_valid), 64'(0));
    chk("drain_no_req", 64'(mem_req), 64'(0));
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(0, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("redirect_req", 64'(mem_req), 64'(1));
    chk("redirect_addr", 64'(mem_addr), 64'h100);
    chk("redirect_count", 64'(count), 64'(0));

    // Redirect colliding with the response.
    cycle(100, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(0, 100, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("collide_req", 64'(mem_req), 64'(1));
    chk("collide_addr", 64'(mem_addr), 64'h200);
    chk("collide_count", 64'(count), 64'(0));

    // Stall holds the queue while fetching continues.
    repeat (12) cycle(100, 100, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("stall_count", 64'(count), 64'(4));
    chk("stall_no_req", 64'(mem_req), 64'(0));
    chk("stall_head", 64'(inst_pc), 64'h200);
    cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("unstall_head", 64'(inst_pc), 64'h204);
    chk("unstall_count", 64'(count), 64'(3));
    repeat (4) cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("unstall_empty", 64'(count), 64'(0));

    // Reset during WAIT, stale response after release.
    cycle(100, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst_val = 1'b0;
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("midreset_count", 64'(count), 64'(0));
    chk("midreset_no_req", 64'(mem_req), 64'(0));
    rst_val = 1'b1;
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("midreset_idle", 64'(mem_req), 64'(0));
    cycle(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("midreset_req", 64'(mem_req), 64'(1));
    chk("midreset_addr", 64'(mem_addr), 64'(RESET_PC));
    chk("midreset_stale_dropped", 64'(count), 64'(0));

    // Random traffic.
    rand_data = 1'b1;
    for (int seg = 0; seg < 30; seg++) begin
      gp = int'($urandom_range(20, 100));
      rp = int'($urandom_range(20, 100));
      for (int i = 0; i < 100; i++) begin
        rst_val = ($urandom_range(199) != 0);
        cycle(gp, rp, ($urandom_range(9) < 7), ($urandom_range(9) < 2),
              ($urandom_range(19) == 0), $urandom, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
